// File: rtl/dot_lane_renderer.sv
// dot_lane_renderer: maps scanned pixels onto an 8x8 tile grid, fetches each
// tile's 2-bit glyph code from a host-written code memory, addresses the glyph ROM
// and returns the selected dot with the syncs delayed to match (latency 2).
// Ports: Clk/Reset (sync, active-high); DrawX/DrawY/pix_valid/hs_in/vs_in pixel in;
// code_we/code_idx/code_wdata code write; cursor_idx blink tile; rom_addr/rom_data
// glyph ROM; dot_on/dot_code/hs_out/vs_out/pix_valid_out aligned outputs.
// Optional: define DOT_LANE_BLINK_EN for the frame-counted cursor blink.
module dot_lane_renderer #(
  parameter int ORIGIN_X     = 64,
  parameter int ORIGIN_Y     = 400,
  parameter int GRID_COLS    = 16,
  parameter int GRID_ROWS    = 2,
  parameter int BLINK_FRAMES = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       pix_valid,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic       code_we,
  input  logic [4:0] code_idx,
  input  logic [1:0] code_wdata,
  input  logic [4:0] cursor_idx,
  output logic [4:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       dot_on,
  output logic [1:0] dot_code,
  output logic       hs_out,
  output logic       vs_out,
  output logic       pix_valid_out
);

  localparam int ENTRIES = GRID_COLS * GRID_ROWS;
  localparam logic [10:0] X_LO = 11'(ORIGIN_X);
  localparam logic [10:0] X_HI = 11'(ORIGIN_X + 8 * GRID_COLS);
  localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
  localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + 8 * GRID_ROWS);

  typedef struct packed {
    logic [4:0] tile;
    logic [2:0] px;
    logic [2:0] py;
    logic       ig;
    logic [1:0] code;
    logic       hs;
    logic       vs;
    logic       pv;
  } s1_t;

  typedef struct packed {
    logic       dot;
    logic [1:0] code;
    logic       hs;
    logic       vs;
    logic       pv;
  } s2_t;

  localparam s1_t S1_RST = '{tile: 5'd0, px: 3'd0, py: 3'd0, ig: 1'b0,
                             code: 2'd0, hs: 1'b1, vs: 1'b1, pv: 1'b0};
  localparam s2_t S2_RST = '{dot: 1'b0, code: 2'd0, hs: 1'b1, vs: 1'b1,
                             pv: 1'b0};

  logic [1:0] mem_q [ENTRIES];
  logic [1:0] mem_d [ENTRIES];
  s1_t        s1_q, s1_d;
  s2_t        s2_q, s2_d;
  logic [9:0] dx, dy, tile_wide;
  logic [1:0] rd_code;
  logic       inv;

  always_comb begin
    mem_d = mem_q;
    if (code_we && ({1'b0, code_idx} < 6'(ENTRIES)))
      mem_d[code_idx] = code_wdata;
  end

  // Code is read as the pixel enters stage 1, so a write on the same
  // edge is seen only by the following pixel.
  always_comb begin
    dx = DrawX - X_LO[9:0];
    dy = DrawY - Y_LO[9:0];
    tile_wide = {3'b0, dy[9:3]} * 10'(GRID_COLS) + {3'b0, dx[9:3]};
    rd_code = 2'd0;
    if (tile_wide < 10'(ENTRIES))
      rd_code = mem_q[tile_wide[4:0]];
    s1_d.ig = pix_valid
            & ({1'b0, DrawX} >= X_LO) & ({1'b0, DrawX} < X_HI)
            & ({1'b0, DrawY} >= Y_LO) & ({1'b0, DrawY} < Y_HI);
    s1_d.tile = tile_wide[4:0];
    s1_d.px = dx[2:0];
    s1_d.py = dy[2:0];
    s1_d.code = s1_d.ig ? rd_code : 2'd0;
    s1_d.hs = hs_in;
    s1_d.vs = vs_in;
    s1_d.pv = pix_valid;
  end

  assign rom_addr = s1_q.ig ? {s1_q.code, s1_q.py} : 5'd0;

  // ~px selects bit 7-px: MSB is the leftmost dot.
  always_comb begin
    s2_d.dot = s1_q.ig & (rom_data[~s1_q.px] ^ inv);
    s2_d.code = s1_q.ig ? s1_q.code : 2'd0;
    s2_d.hs = s1_q.hs;
    s2_d.vs = s1_q.vs;
    s2_d.pv = s1_q.pv;
  end

`ifdef DOT_LANE_BLINK_EN
  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          blink_q, blink_d;
  logic          vs_prev_q, vs_prev_d;

  always_comb begin
    cnt_d = cnt_q;
    blink_d = blink_q;
    vs_prev_d = vs_in;
    if (vs_prev_q & ~vs_in) begin
      if (cnt_q == CW'(BLINK_FRAMES - 1)) begin
        cnt_d = '0;
        blink_d = ~blink_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
      blink_q <= 1'b0;
      vs_prev_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      blink_q <= blink_d;
      vs_prev_q <= vs_prev_d;
    end
  end

  assign inv = blink_q & s1_q.ig & (s1_q.tile == cursor_idx);
`else
  logic unused_cursor;
  assign unused_cursor = ^cursor_idx;
  assign inv = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mem_q <= '{default: 2'd0};
      s1_q <= S1_RST;
      s2_q <= S2_RST;
    end else begin
      mem_q <= mem_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign dot_on = s2_q.dot;
  assign dot_code = s2_q.code;
  assign hs_out = s2_q.hs;
  assign vs_out = s2_q.vs;
  assign pix_valid_out = s2_q.pv;

endmodule

// File: tb/tb_dot_lane_renderer.sv
// Bench for dot_lane_renderer: pixel-level reference model plus directed
// probes with hand-computed dots, codes and ROM addresses.
module tb_dot_lane_renderer;

  localparam int OX = 64;
  localparam int OY = 400;
  localparam int COLS = 16;
  localparam int ROWS = 2;
  localparam int BF = 2;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic       pix_valid = 1'b0, hs_in = 1'b1, vs_in = 1'b1;
  logic       code_we = 1'b0;
  logic [4:0] code_idx = '0, cursor_idx = '0;
  logic [1:0] code_wdata = '0;
  logic [4:0] rom_addr;
  logic [7:0] rom_data;
  logic       dot_on, hs_out, vs_out, pix_valid_out;
  logic [1:0] dot_code;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;
  int ones_seen = 0;

  always #5 Clk = ~Clk;

  dot_lane_renderer #(
    .ORIGIN_X(OX), .ORIGIN_Y(OY), .GRID_COLS(COLS),
    .GRID_ROWS(ROWS), .BLINK_FRAMES(BF)
  ) dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .pix_valid(pix_valid), .hs_in(hs_in), .vs_in(vs_in),
    .code_we(code_we), .code_idx(code_idx), .code_wdata(code_wdata),
    .cursor_idx(cursor_idx), .rom_addr(rom_addr), .rom_data(rom_data),
    .dot_on(dot_on), .dot_code(dot_code), .hs_out(hs_out),
    .vs_out(vs_out), .pix_valid_out(pix_valid_out)
  );

  function automatic logic [7:0] glyph(input logic [4:0] a);
    case (a[4:3])
      2'd0: glyph = 8'h00;
      2'd1: glyph = 8'h10;
      2'd2: glyph = 8'h08;
      default: glyph = {a[2:0], 5'b10101};
    endcase
  endfunction

  assign rom_data = glyph(rom_addr);

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one pixel record per stage.
  int  mem [32];
  bit  m1_ig, m1_raw, m1_hs = 1, m1_vs = 1, m1_pv;
  int  m1_tile, m1_code, m1_py;
  bit  m2_dot, m2_hs = 1, m2_vs = 1, m2_pv;
  int  m2_code;
  int  nfalls;
  bit  vs_prev = 1;

  always @(posedge Clk) begin
    if (Reset) begin
      foreach (mem[i]) mem[i] = 0;
      m1_ig = 0; m1_raw = 0; m1_hs = 1; m1_vs = 1; m1_pv = 0;
      m1_tile = 0; m1_code = 0; m1_py = 0;
      m2_dot = 0; m2_code = 0; m2_hs = 1; m2_vs = 1; m2_pv = 0;
      nfalls = 0; vs_prev = 1;
    end else begin
      bit inv;
      bit ig;
      logic [7:0] row;
      int px;
      inv = 0;
`ifdef DOT_LANE_BLINK_EN
      inv = ((nfalls / BF) % 2 == 1) && (m1_tile == int'(cursor_idx));
`endif
      m2_dot = m1_ig && (m1_raw ^ inv);
      m2_code = m1_ig ? m1_code : 0;
      m2_hs = m1_hs; m2_vs = m1_vs; m2_pv = m1_pv;
      ig = pix_valid && DrawX >= OX && DrawX < OX + 8 * COLS
        && DrawY >= OY && DrawY < OY + 8 * ROWS;
      m1_ig = ig; m1_hs = hs_in; m1_vs = vs_in; m1_pv = pix_valid;
      m1_code = 0; m1_raw = 0; m1_py = 0; m1_tile = -1;
      if (ig) begin
        m1_tile = (int'(DrawY) - OY) / 8 * COLS + (int'(DrawX) - OX) / 8;
        m1_py = (int'(DrawY) - OY) % 8;
        px = (int'(DrawX) - OX) % 8;
        m1_code = mem[m1_tile];
        row = glyph(5'(m1_code * 8 + m1_py));
        m1_raw = row[7 - px];
      end
      if (code_we && code_idx < COLS * ROWS) mem[code_idx] = code_wdata;
      if (vs_prev && !vs_in) nfalls++;
      vs_prev = vs_in;
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("dot_on", dot_on, m2_dot);
      chk("dot_code", dot_code, m2_code);
      chk("hs_out", hs_out, m2_hs);
      chk("vs_out", vs_out, m2_vs);
      chk("pix_valid_out", pix_valid_out, m2_pv);
      chk("rom_addr", rom_addr, m1_ig ? m1_code * 8 + m1_py : 0);
      if (dot_on) ones_seen++;
    end
  end

  task automatic idle();
    pix_valid = 0; DrawX = '0; DrawY = '0; code_we = 0;
  endtask

  task automatic wr(input int idx, input int data);
    @(negedge Clk);
    code_we = 1; code_idx = 5'(idx); code_wdata = 2'(data);
    @(negedge Clk);
    code_we = 0;
  endtask

  task automatic probe(input string nm, input int x, input int y,
                       input int ea, input int ed, input int ec);
    @(negedge Clk);
    DrawX = 10'(x); DrawY = 10'(y); pix_valid = 1;
    @(negedge Clk);
    idle();
    chk({nm, "_addr"}, rom_addr, ea);
    @(negedge Clk);
    chk({nm, "_dot"}, dot_on, ed);
    chk({nm, "_code"}, dot_code, ec);
  endtask

  initial begin
    idle();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk_en = 1;
    chk("rst_dot", dot_on, 0);
    chk("rst_code", dot_code, 0);
    chk("rst_hs", hs_out, 1);
    chk("rst_vs", vs_out, 1);
    chk("rst_pv", pix_valid_out, 0);
    Reset = 0;

    // Partial frame scan with no writes: blank everywhere.
    for (int y = 396; y < 420; y++) begin
      for (int x = 56; x < 200; x++) begin
        @(negedge Clk);
        DrawX = 10'(x); DrawY = 10'(y);
        pix_valid = (x < 196);
        hs_in = !(x >= 196);
        vs_in = !(y == 398 && x < 60);
      end
    end
    @(negedge Clk);
    idle(); hs_in = 1; vs_in = 1;
    repeat (3) @(negedge Clk);
    chk("scan_no_dots", ones_seen, 0);

    wr(0, 1);
    probe("p67", 67, 404, 5'b01100, 1, 1);
    probe("p66", 66, 404, 5'b01100, 0, 1);
    wr(17, 2);
    probe("p76", 76, 412, 5'b10100, 1, 2);
    probe("p63", 63, 400, 0, 0, 0);
    probe("p192", 192, 400, 0, 0, 0);

    // Write idx 5 while a pixel of tile 5 enters: old code for it.
    @(negedge Clk);
    code_we = 1; code_idx = 5'd5; code_wdata = 2'd3;
    DrawX = 10'd106; DrawY = 10'd401; pix_valid = 1;
    @(negedge Clk);
    code_we = 0; DrawX = 10'd107;
    @(negedge Clk);
    idle();
    chk("same_cyc_old_code", dot_code, 0);
    @(negedge Clk);
    chk("next_new_code", dot_code, 3);
    chk("next_new_dot", dot_on, 1);

    // Cursor blink.
    @(negedge Clk);
    Reset = 1;
    @(negedge Clk);
    Reset = 0;
    cursor_idx = 5'd3;
    wr(3, 1);
    probe("cur_norm", 91, 404, 5'b01100, 1, 1);
    repeat (2) begin
      @(negedge Clk); vs_in = 0;
      @(negedge Clk);
      @(negedge Clk); vs_in = 1;
      @(negedge Clk);
    end
`ifdef DOT_LANE_BLINK_EN
    probe("cur_inv_a", 91, 404, 5'b01100, 0, 1);
    probe("cur_inv_b", 88, 400, 5'b01000, 1, 1);
`else
    probe("cur_inv_a", 91, 404, 5'b01100, 1, 1);
    probe("cur_inv_b", 88, 400, 5'b01000, 0, 1);
`endif

    // Reset in the middle of a line.
    for (int x = 64; x < 72; x++) begin
      @(negedge Clk);
      DrawX = 10'(x); DrawY = 10'd404; pix_valid = 1; hs_in = 0;
    end
    @(negedge Clk);
    Reset = 1; DrawX = 10'd72;
    @(negedge Clk);
    chk("mid_rst_pv", pix_valid_out, 0);
    chk("mid_rst_hs", hs_out, 1);
    chk("mid_rst_dot", dot_on, 0);
    Reset = 0; DrawX = 10'd73;
    @(negedge Clk);
    chk("resume_pv_1", pix_valid_out, 0);
    DrawX = 10'd74;
    @(negedge Clk);
    chk("resume_pv_2", pix_valid_out, 1);
    idle(); hs_in = 1;
    repeat (3) @(negedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
